// File: rtl/pipe_mdu_pkg.sv
// pipe_mdu_pkg: shared op encodings, HI/LO read encodings and FSM state
// type for the EXE-stage multiply/divide sequencer.
package pipe_mdu_pkg;
    localparam logic [2:0] MDU_NOP   = 3'b000;
    localparam logic [2:0] MDU_MULT  = 3'b001;
    localparam logic [2:0] MDU_MULTU = 3'b010;
    localparam logic [2:0] MDU_DIV   = 3'b011;
    localparam logic [2:0] MDU_DIVU  = 3'b100;
    localparam logic [2:0] MDU_MTHI  = 3'b101;
    localparam logic [2:0] MDU_MTLO  = 3'b110;

    localparam logic [1:0] HL_NONE = 2'b00;
    localparam logic [1:0] HL_MFHI = 2'b01;
    localparam logic [1:0] HL_MFLO = 2'b10;

    localparam int ITER_COUNT = 32;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} mdu_state_t;

    // Magnitude of a value that is only treated as two's complement for signed ops.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? -v : v;
    endfunction
endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: 64-bit shift register doing one shift-add multiply step or one
// restoring-divide step per enable; raw unsigned result on result.
module mdu_iter (
    input  logic        clock,
    input  logic        resetn,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);
    logic [63:0] acc;
    logic [31:0] dvs;
    logic [32:0] sum;
    logic [31:0] sub;
    logic        ge;

    // Multiply keeps {partial, multiplier}; divide keeps {remainder, quotient}.
    assign sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, dvs} : 33'd0);
    assign ge  = acc[63:31] >= {1'b0, dvs};
    assign sub = acc[62:31] - dvs;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            acc <= '0;
            dvs <= '0;
        end else if (load) begin
            acc <= {32'd0, a};
            dvs <= b;
        end else if (step) begin
            acc <= !is_div ? {sum, acc[31:1]} :
                   ge      ? {sub, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
        end
    end

    assign result = acc;
endmodule

// File: rtl/pipe_mdu_ctrl.sv
// pipe_mdu_ctrl: EXE-stage multiply/divide sequencer owning HI/LO; stalls
// the front of the pipeline while an MDU-related instruction meets a busy unit.
module pipe_mdu_ctrl
    import pipe_mdu_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic [2:0]  eop,
    input  logic [1:0]  emfhilo,
    input  logic [31:0] ea,
    input  logic [31:0] eb,
    output logic        estall,
    output logic [31:0] ehilo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);
    mdu_state_t  state, state_nx;
    logic [4:0]  cnt;
    logic        is_div, is_sgn, sa, sb, dz;
    logic [31:0] dz_a;
    logic        start, op_div, op_sgn, mdu_rel, load, step;
    logic [63:0] raw, prod;
    logic [31:0] quo, rem, fix_hi, fix_lo;

    assign start   = (state == ST_IDLE) && (eop >= MDU_MULT) && (eop <= MDU_DIVU);
    assign op_div  = (eop == MDU_DIV) || (eop == MDU_DIVU);
    assign op_sgn  = (eop == MDU_MULT) || (eop == MDU_DIV);
    assign mdu_rel = ((eop >= MDU_MULT) && (eop <= MDU_MTLO)) ||
                     (emfhilo == HL_MFHI) || (emfhilo == HL_MFLO);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: state_nx = start ? ST_BUSY : ST_IDLE;
            ST_BUSY: state_nx = (cnt == 5'(ITER_COUNT - 1)) ? ST_DONE : ST_BUSY;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = state != ST_IDLE;
        estall = busy && mdu_rel;
        load   = start;
        step   = state == ST_BUSY;
        ehilo  = (emfhilo == HL_MFHI) ? hi : (emfhilo == HL_MFLO) ? lo : '0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt    <= '0;
            is_div <= 1'b0;
            is_sgn <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            dz     <= 1'b0;
            dz_a   <= '0;
        end else if (start) begin
            cnt    <= '0;
            is_div <= op_div;
            is_sgn <= op_sgn;
            sa     <= ea[31];
            sb     <= eb[31];
            dz     <= op_div && (eb == '0);
            dz_a   <= ea;
        end else if (step) begin
            cnt <= cnt + 5'd1;
        end
    end

    mdu_iter u_iter (
        .clock  (clock),
        .resetn (resetn),
        .load   (load),
        .step   (step),
        .is_div (is_div),
        .a      (abs32(ea, op_sgn)),
        .b      (abs32(eb, op_sgn)),
        .result (raw)
    );

    // Remainder follows the dividend's sign; quotient/product follow sign xor.
    assign prod   = (is_sgn && (sa ^ sb)) ? -raw : raw;
    assign quo    = (is_sgn && (sa ^ sb)) ? -raw[31:0] : raw[31:0];
    assign rem    = (is_sgn && sa) ? -raw[63:32] : raw[63:32];
    assign fix_hi = dz ? dz_a : is_div ? rem : prod[63:32];
    assign fix_lo = dz ? '1   : is_div ? quo : prod[31:0];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (state == ST_DONE) begin
            hi <= fix_hi;
            lo <= fix_lo;
        end else if (state == ST_IDLE && eop == MDU_MTHI) begin
            hi <= ea;
        end else if (state == ST_IDLE && eop == MDU_MTLO) begin
            lo <= ea;
        end
    end
endmodule

// File: tb/tb_pipe_mdu_ctrl.sv
// tb_pipe_mdu_ctrl: directed vector table plus hand sequences for reset,
// stall and back-to-back issue behaviour of pipe_mdu_ctrl.
module tb_pipe_mdu_ctrl;
    logic        clock = 1'b0;
    logic        resetn;
    logic [2:0]  eop;
    logic [1:0]  emfhilo;
    logic [31:0] ea, eb;
    logic        estall, busy;
    logic [31:0] ehilo, hi, lo;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       nm;
    } vec_t;
    vec_t vecs[10];

    always #5 clock = ~clock;

    pipe_mdu_ctrl dut (
        .clock   (clock),
        .resetn  (resetn),
        .eop     (eop),
        .emfhilo (emfhilo),
        .ea      (ea),
        .eb      (eb),
        .estall  (estall),
        .ehilo   (ehilo),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy)
    );

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Entered just after an edge (cycle 0); leaves just after the edge ending cycle 34.
    task automatic run_op(input vec_t v);
        bit ok;
        eop = v.op; ea = v.a; eb = v.b; emfhilo = 2'b00;
        @(negedge clock);
        chk({v.nm, ".issue_stall"}, 32'(estall), 32'd0);
        nxt();
        eop = 3'b000; ea = $urandom; eb = $urandom;
        ok = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clock);
            if (busy !== 1'b1 || estall !== 1'b0) ok = 1'b0;
            nxt();
        end
        chk({v.nm, ".busy_run"}, 32'(ok), 32'd1);
        @(negedge clock);
        chk({v.nm, ".busy_end"}, 32'(busy), 32'd0);
        chk({v.nm, ".hi"}, hi, v.hi);
        chk({v.nm, ".lo"}, lo, v.lo);
        nxt();
    endtask

    initial begin
        bit ok;
        vecs[0] = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
        vecs[1] = '{3'b001, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, "mult_m3x5"};
        vecs[2] = '{3'b001, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, "mult_7xm6"};
        vecs[3] = '{3'b011, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7d2"};
        vecs[4] = '{3'b011, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div_7dm2"};
        vecs[5] = '{3'b011, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, "div_ovf"};
        vecs[6] = '{3'b100, 32'd100,      32'd7,        32'd2,        32'd14,       "divu_100d7"};
        vecs[7] = '{3'b100, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, "divu_dz"};
        vecs[8] = '{3'b011, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, "div_dz"};
        vecs[9] = '{3'b010, 32'h00010000, 32'h00030000, 32'd3,        32'd0,        "multu_shift"};

        resetn = 1'b0; eop = 3'b000; emfhilo = 2'b00; ea = '0; eb = '0;
        repeat (3) nxt();
        resetn = 1'b1;
        @(negedge clock);
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.estall", 32'(estall), 32'd0);
        emfhilo = 2'b01;
        #1 chk("rst.ehilo", ehilo, 32'd0);
        emfhilo = 2'b00;
        nxt();

        // Reset in the middle of a MULT discards it and clears HI/LO.
        eop = 3'b101; ea = 32'h55;
        nxt();
        @(negedge clock);
        chk("mthi_pre_rst", hi, 32'h55);
        nxt();
        eop = 3'b001; ea = 32'd5; eb = 32'd7;
        nxt();
        eop = 3'b000;
        repeat (9) nxt();
        @(negedge clock);
        chk("mid.busy_before", 32'(busy), 32'd1);
        resetn = 1'b0;
        eop = 3'b001;
        #1;
        chk("mid.busy", 32'(busy), 32'd0);
        chk("mid.estall", 32'(estall), 32'd0);
        chk("mid.hi", hi, 32'd0);
        chk("mid.lo", lo, 32'd0);
        eop = 3'b000;
        nxt();
        resetn = 1'b1;
        nxt();
        run_op('{3'b010, 32'd3, 32'd4, 32'd0, 32'd12, "after_rst"});

        for (int i = 0; i < 10; i++) run_op(vecs[i]);

        // MFLO right behind a MULT stalls until the result lands.
        eop = 3'b001; ea = 32'hFFFFFFFD; eb = 32'd5;
        nxt();
        eop = 3'b000; emfhilo = 2'b10;
        ok = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clock);
            if (estall !== 1'b1) ok = 1'b0;
            nxt();
        end
        chk("mflo.stall_run", 32'(ok), 32'd1);
        @(negedge clock);
        chk("mflo.estall_end", 32'(estall), 32'd0);
        chk("mflo.ehilo", ehilo, 32'hFFFFFFF1);
        chk("mflo.hi", hi, 32'hFFFFFFFF);
        nxt();
        emfhilo = 2'b00;

        // MTHI/MTLO are visible to a read in the very next cycle.
        eop = 3'b101; ea = 32'h1234;
        @(negedge clock);
        chk("mthi.estall", 32'(estall), 32'd0);
        nxt();
        eop = 3'b110; ea = 32'h5678; emfhilo = 2'b01;
        @(negedge clock);
        chk("mfhi.ehilo", ehilo, 32'h1234);
        chk("mfhi.estall", 32'(estall), 32'd0);
        nxt();
        eop = 3'b000; emfhilo = 2'b10;
        @(negedge clock);
        chk("mflo2.ehilo", ehilo, 32'h5678);
        nxt();
        emfhilo = 2'b00;

        // A DIVU presented behind a MULT is held, issues at cycle 34, result at 68.
        eop = 3'b001; ea = 32'd2; eb = 32'd3;
        nxt();
        eop = 3'b100; ea = 32'd100; eb = 32'd7;
        ok = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clock);
            if (estall !== 1'b1) ok = 1'b0;
            nxt();
        end
        chk("b2b.stall_run", 32'(ok), 32'd1);
        @(negedge clock);
        chk("b2b.estall34", 32'(estall), 32'd0);
        chk("b2b.mult_lo", lo, 32'd6);
        nxt();
        eop = 3'b000; ea = '0; eb = '0;
        ok = 1'b1;
        for (int c = 35; c <= 67; c++) begin
            @(negedge clock);
            if (busy !== 1'b1) ok = 1'b0;
            nxt();
        end
        chk("b2b.busy_run", 32'(ok), 32'd1);
        @(negedge clock);
        chk("b2b.busy68", 32'(busy), 32'd0);
        chk("b2b.hi", hi, 32'd2);
        chk("b2b.lo", lo, 32'd14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_mdu_ctrl.md
# pipe_mdu_ctrl

Multiply/divide sequencer for the pipelined CPU's EXE stage. It accepts MULT/MULTU/DIV/DIVU from the instruction in EXE and runs a 32-iteration shift-add / restoring-divide unit. It owns the HI/LO registers, serves MFHI/MFLO/MTHI/MTLO, and raises `estall` to freeze the front of the pipeline whenever an EXE instruction needs HI/LO or the unit while it is busy.

## Interface
Parameters:
- none (width fixed at 32)

Ports:
- `clock`  in  1  pipeline clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `eop`  in  3  EXE MDU op: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 NOP
- `emfhilo`  in  2  HI/LO read: 01 MFHI, 10 MFLO, 00/11 none
- `ea`, `eb`  in  32 each  forwarded operands (rs, rt)
- `estall`  out  1  hold IF/ID/EXE this cycle
- `ehilo`  out  32  MFHI/MFLO result, muxed into EXE result by the top level
- `hi`, `lo`  out  32 each  architectural HI/LO
- `busy`  out  1  unit not IDLE

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE + start op (001–100), i.e. issue:
  - `estall=0`
  - capture |ea|, |eb| (signed ops) or raw (unsigned), operand signs, op kind
  - counter=0, next state BUSY
- BUSY: one iteration per cycle. After the 32nd iteration (counter==31), next state DONE.
- DONE: sign fix-up, write HI/LO at end of cycle, next state IDLE.
- Multiply: LO = low 32 bits, HI = high 32 bits of the 64-bit product. Signed: negate the 64-bit product if the operand signs differ.
- Divide: LO = quotient, HI = remainder.
  - Signed: quotient negated if signs differ; remainder takes the dividend's sign.
  - 0x80000000 / −1 → LO=0x80000000, HI=0 (falls out of the abs method).
- Divide by zero (signed or unsigned): LO=0xFFFFFFFF, HI=`ea`; fix-up is bypassed.
- MTHI/MTLO in IDLE: write `ea` to HI/LO at end of cycle, no stall.
- `estall` is 1 iff state≠IDLE and the EXE instruction is MDU-related: `eop` in 001–110 or `emfhilo` in 01/10. This is combinational.
- Non-MDU instructions proceed while BUSY/DONE (out-of-order completion is legal: only MDU ops touch HI/LO).
- A stalled start op is re-presented unchanged by the pipeline and issues in the first IDLE cycle.
- `ehilo`: `hi` for 01, `lo` for 10, otherwise 0. It is combinational from the registers and valid only when `estall=0`.
- Reset (any time, including mid-operation): state IDLE, counter 0, HI=LO=0, all internal registers 0. Outputs then read `busy=0`, `estall=0`, `ehilo=0`, `hi=lo=0`, and any in-flight op is discarded.

## Timing
- Issue in cycle T; BUSY T+1..T+32; DONE T+33; HI/LO updated at the edge ending T+33; `busy=0` from T+34.
- Minimum spacing between two mul/div issues: 34 cycles.
- MFHI/MFLO after an issue: stalled T+1..T+33, completes T+34 with the new value.
- MTHI/MTLO followed by MFHI/MFLO in the next cycle: reads the new value, with no bypass needed.
- Start op with `emfhilo`≠00 in the same instruction cannot occur. If it does, the start has priority and `ehilo` is ignored.
- No combinational path from `ea`/`eb` to `estall`.

## Structure
- Shared package `pipe_mdu_pkg`:
  - `eop` encodings (MDU_NOP, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO)
  - `emfhilo` encodings
  - FSM state type
  - ITER_COUNT=32
- One sub-module, `mdu_iter`: the 64-bit accumulator/remainder-quotient shift register. It performs one shift-add or restoring-subtract step per enable and exposes the raw 64-bit result.
- `pipe_mdu_ctrl` holds the FSM, counter, sign capture, fix-up, HI/LO and stall logic.

## Test plan
- Reset, then release → `hi=lo=0`, `busy=0`, `estall=0`, `ehilo=0`; assert `resetn` low at BUSY cycle 10 of a MULT → immediately IDLE, `hi=lo=0`; a following MULTU 3×4 gives LO=12, HI=0.
- MULTU 0xFFFFFFFF×0xFFFFFFFF issued cycle 0 → `busy` 1 for cycles 1–33, HI=0xFFFFFFFE, LO=0x00000001 from cycle 34; non-MDU ops in cycles 1–33 see `estall=0`.
- MULT −3×5, then MFLO presented cycle 1 → `estall=1` cycles 1–33, cycle 34 `ehilo`=0xFFFFFFF1; HI=0xFFFFFFFF.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0; DIVU 100/7 → LO=14, HI=2.
- DIVU 5/0 → LO=0xFFFFFFFF, HI=5; DIV 0xFFFFFFFB/0 → LO=0xFFFFFFFF, HI=0xFFFFFFFB.
- MTHI 0x1234 then MFHI next cycle → `ehilo`=0x1234, no stall. MULT issued, then DIV presented cycle 1 → DIV stalled until cycle 34, issues then, result at cycle 68.
